ex_muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage.
- Successor to the fixed 32-bit divider. Adds width parametrisation, iterative signed/unsigned multiply, annul support and a clean stall/done handshake.
- Sits beside the EX sub-units. Its HI/LO/whilo outputs are ORed into the EX HI/LO write path, and its stall output feeds the pipeline stall controller.

---
 rtl/ex_muldiv_iter.sv | 204 ++++++++++++++++++++
 tb/tb_ex_muldiv_iter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage.
// Multiply is shift-add (LSB first), divide is restoring (MSB first), one bit
// per cycle. Operands are reduced to magnitudes at launch and the sign is
// re-applied on the final iteration so hi_o/lo_o are already corrected in DONE.
// Optional feature macro: MULDIV_DIVZERO_EN (early divide-by-zero completion).
module ex_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             whilo_o,
  output logic             divzero_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   isDiv_q;
  logic                   negRes_q;
  logic                   negRem_q;
  logic [WIDTH-1:0]       divisor_q;
  logic [WIDTH-1:0]       accHi_q;
  logic [WIDTH-1:0]       accLo_q;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;

  logic                   signA_d;
  logic                   signB_d;
  logic [WIDTH-1:0]       absA_d;
  logic [WIDTH-1:0]       absB_d;
  logic [WIDTH:0]         mulSum_d;
  logic [WIDTH:0]         divShift_d;
  logic [WIDTH:0]         divDiff_d;
  logic                   divFits_d;
  logic [WIDTH-1:0]       stepHi_d;
  logic [WIDTH-1:0]       stepLo_d;
  logic [2*WIDTH-1:0]     prodRaw_d;
  logic [2*WIDTH-1:0]     prodFix_d;
  logic [WIDTH-1:0]       quoFix_d;
  logic [WIDTH-1:0]       remFix_d;
  logic [WIDTH-1:0]       resHi_d;
  logic [WIDTH-1:0]       resLo_d;

  // Operand magnitudes and signs; op_i[0]=0 selects the signed variants
  always_comb begin
    signA_d = ~op_i[0] & opa_i[WIDTH-1];
    signB_d = ~op_i[0] & opb_i[WIDTH-1];
    absA_d  = signA_d ? -opa_i : opa_i;
    absB_d  = signB_d ? -opb_i : opb_i;
  end

  // One iteration of the datapath plus the sign-corrected final result
  always_comb begin
    mulSum_d   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, divisor_q} : '0);
    divShift_d = {accHi_q, accLo_q[WIDTH-1]};
    divDiff_d  = divShift_d - {1'b0, divisor_q};
    divFits_d  = ~divDiff_d[WIDTH];
    if (isDiv_q) begin
      stepHi_d = divFits_d ? divDiff_d[WIDTH-1:0] : divShift_d[WIDTH-1:0];
      stepLo_d = {accLo_q[WIDTH-2:0], divFits_d};
    end else begin
      stepHi_d = mulSum_d[WIDTH:1];
      stepLo_d = {mulSum_d[0], accLo_q[WIDTH-1:1]};
    end
    prodRaw_d = {stepHi_d, stepLo_d};
    prodFix_d = negRes_q ? -prodRaw_d : prodRaw_d;
    quoFix_d  = negRes_q ? -stepLo_d : stepLo_d;
    remFix_d  = negRem_q ? -stepHi_d : stepHi_d;
    if (isDiv_q) begin
      resHi_d = remFix_d;
      resLo_d = quoFix_d;
    end else begin
      resHi_d = prodFix_d[2*WIDTH-1:WIDTH];
      resLo_d = prodFix_d[WIDTH-1:0];
    end
  end

`ifdef MULDIV_DIVZERO_EN
  logic divzero_q;

  // Sequencer and datapath registers, with early exit on divide by zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divisor_q <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !annul_i) begin
            isDiv_q   <= op_i[1];
            negRes_q  <= signA_d ^ signB_d;
            negRem_q  <= signA_d;
            divisor_q <= op_i[1] ? absB_d : absA_d;
            accHi_q   <= '0;
            accLo_q   <= op_i[1] ? absA_d : absB_d;
            cnt_q     <= CNT_W'(WIDTH);
            if (op_i[1] && (opb_i == '0)) begin
              state_q   <= DONE;
              hi_q      <= '0;
              lo_q      <= '0;
              divzero_q <= 1'b1;
            end else begin
              state_q   <= CALC;
              divzero_q <= 1'b0;
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            accHi_q <= stepHi_d;
            accLo_q <= stepLo_d;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= DONE;
              hi_q    <= resHi_d;
              lo_q    <= resLo_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign divzero_o = divzero_q;
`else
  // Sequencer and datapath registers; divide by zero runs the full course
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divisor_q <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !annul_i) begin
            isDiv_q   <= op_i[1];
            negRes_q  <= signA_d ^ signB_d;
            negRem_q  <= signA_d;
            divisor_q <= op_i[1] ? absB_d : absA_d;
            accHi_q   <= '0;
            accLo_q   <= op_i[1] ? absA_d : absB_d;
            cnt_q     <= CNT_W'(WIDTH);
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            accHi_q <= stepHi_d;
            accLo_q <= stepLo_d;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= DONE;
              hi_q    <= resHi_d;
              lo_q    <= resLo_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign divzero_o = 1'b0;
`endif

  assign stall_o = ((state_q == IDLE) && start_i && !annul_i) || (state_q == CALC);
  assign done_o  = (state_q == DONE) && !annul_i;
  assign whilo_o = done_o;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Scoreboard bench for ex_muldiv_iter: the stimulus side pushes expected
// results computed with plain arithmetic, a monitor pops them on done_o.
module tb_ex_muldiv_iter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           doneCyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic         annul_i;
  logic [W-1:0] opa_i;
  logic [W-1:0] opb_i;
  logic         stall_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         whilo_o;
  logic         divzero_o;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sbQ[$];

  ex_muldiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .annul_i(annul_i),
    .opa_i(opa_i), .opb_i(opb_i), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .divzero_o(divzero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit isEarlyDz(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MULDIV_DIVZERO_EN
    return op[1] && (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference result from ordinary integer arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint p;
    longint unsigned pu;
    int sa, sb;
    e.dz = 1'b0;
    e.doneCyc = 0;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        {e.hi, e.lo} = p;
      end
      2'b01: begin
        pu = longint'({32'b0, a}) * longint'({32'b0, b});
        {e.hi, e.lo} = pu;
      end
      2'b10: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = a[W-1] ? 32'h1 : 32'hFFFFFFFF;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.lo = 32'h80000000;
          e.hi = 32'h0;
        end else begin
          e.lo = sa / sb;
          e.hi = sa % sb;
        end
      end
      default: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = 32'hFFFFFFFF;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    if (isEarlyDz(op, b)) begin
      e.hi = '0;
      e.lo = '0;
      e.dz = 1'b1;
    end
    return e;
  endfunction

  // Issue one operation from IDLE and wait (bounded) for its completion
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   lat;
    int   stallCnt;
    bit   got;
    lat = isEarlyDz(op, b) ? 1 : LAT;
    e = model(op, a, b);
    e.doneCyc = cyc + lat;
    sbQ.push_back(e);
    op_i = op;
    opa_i = a;
    opb_i = b;
    start_i = 1'b1;
    stallCnt = 0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        checkOutput("stallInDone", {63'b0, stall_o}, 64'd0);
      end else if (stall_o) begin
        stallCnt++;
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    if (!got) begin
      checkOutput("doneTimeout", 64'd0, 64'd1);
      void'(sbQ.pop_back());
    end
    checkOutput("stallCycles", 64'(stallCnt), 64'(lat));
  endtask

  // Monitor: pop the scoreboard whenever the unit presents a result
  always @(negedge clk) begin
    exp_t e;
    if (rst && (done_o || whilo_o)) begin
      checkOutput("whiloEqDone", {63'b0, whilo_o}, {63'b0, done_o});
      if (done_o) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'd1, 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("hi", {32'b0, hi_o}, {32'b0, e.hi});
          checkOutput("lo", {32'b0, lo_o}, {32'b0, e.lo});
          checkOutput("divzero", {63'b0, divzero_o}, {63'b0, e.dz});
          checkOutput("doneCycle", 64'(cyc), 64'(e.doneCyc));
        end
      end
    end
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           c0;
    rst = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    op_i = 2'b00;
    opa_i = '0;
    opb_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstHi", {32'b0, hi_o}, 64'd0);
    checkOutput("rstLo", {32'b0, lo_o}, 64'd0);
    checkOutput("rstDone", {62'b0, done_o, whilo_o}, 64'd0);
    checkOutput("rstDz", {63'b0, divzero_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'h2);
    applyStimulus(2'b00, -32'sd3, 32'd7);
    applyStimulus(2'b10, -32'sd7, 32'd2);
    applyStimulus(2'b11, 32'd100, 32'd7);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(2'b11, 32'd9, 32'd0);
    applyStimulus(2'b10, -32'sd9, 32'd0);
    applyStimulus(2'b00, 32'h80000000, 32'h80000000);

    $display("[TB] annul in CALC then fresh start");
    op_i = 2'b11;
    opa_i = 32'd5;
    opb_i = 32'd3;
    start_i = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    while (cyc < c0 + 10) begin
      @(posedge clk);
      #1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annulCalcDone", {63'b0, done_o}, 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    checkOutput("annulIdleStall", {63'b0, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("freshStartCycle", 64'(cyc), 64'(c0 + 12));
    applyStimulus(2'b11, 32'd5, 32'd3);

    $display("[TB] annul in DONE");
    op_i = 2'b01;
    opa_i = 32'd11;
    opb_i = 32'd13;
    start_i = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    while (cyc < c0 + LAT) begin
      @(posedge clk);
      #1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annulDoneDone", {62'b0, done_o, whilo_o}, 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    applyStimulus(2'b00, 32'd123, -32'sd45);

    $display("[TB] reset mid-operation");
    op_i = 2'b00;
    opa_i = 32'd77;
    opb_i = 32'd88;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midRstHi", {32'b0, hi_o}, 64'd0);
    checkOutput("midRstLo", {32'b0, lo_o}, 64'd0);
    checkOutput("midRstFlags", {60'b0, done_o, whilo_o, divzero_o, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] random operations");
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      applyStimulus(rop, ra, rb);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
